// File: rtl/clock_field_set_ctrl.sv
// Set-mode controller for the clock display: wrapping field cursor, Up/Down pulses with
// auto-repeat, and an inactivity timeout into lockout. Blink gate option: CLOCK_FIELD_SET_BLINK_EN.
module clock_field_set_ctrl #(
  parameter int NUM_FIELDS  = 3,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10,
  parameter int TIMEOUT     = 3000,
  parameter int BLINK_HALF  = 250
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iTick,
  input  logic                  iSet,
  input  logic                  iBtn_U,
  input  logic                  iBtn_D,
  input  logic                  iBtn_L,
  input  logic                  iBtn_R,
  output logic [NUM_FIELDS-1:0] oUp,
  output logic [NUM_FIELDS-1:0] oDown,
  output logic [NUM_FIELDS-1:0] oSel,
  output logic                  oSetting,
  output logic                  oTimeout,
  output logic                  oBlink
);

  localparam int CUR_W  = $clog2(NUM_FIELDS);
  localparam int HOLD_W = $clog2(REPEAT_DLY + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [CUR_W-1:0]  CUR_TOP     = CUR_W'(NUM_FIELDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DLY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DLY - REPEAT_RATE);
  localparam logic [TO_W-1:0]   TO_MAX      = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [CUR_W-1:0]        cursor_r, cursor_s;
  logic [HOLD_W-1:0]       hold_r, hold_s;
  logic                    arm_r, arm_s;
  logic [TO_W-1:0]         to_r, to_s;
  logic                    prev_u_r, prev_d_r, prev_l_r, prev_r_r;
  logic                    edge_u_s, edge_d_s, edge_l_s, edge_r_s;
  logic [NUM_FIELDS-1:0]   up_s, down_s;
  logic                    timeout_s;
  logic [NUM_FIELDS-1:0]   up_r, down_r, sel_r;
  logic                    setting_r, timeout_r;

  function automatic logic [NUM_FIELDS-1:0] onehot(input logic [CUR_W-1:0] idx);
    return {{(NUM_FIELDS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign edge_u_s = iBtn_U & ~prev_u_r;
  assign edge_d_s = iBtn_D & ~prev_d_r;
  assign edge_l_s = iBtn_L & ~prev_l_r;
  assign edge_r_s = iBtn_R & ~prev_r_r;

  // Next state, cursor, repeat and timeout counters, pulse generation
  always_comb begin
    state_s   = state_r;
    cursor_s  = cursor_r;
    hold_s    = hold_r;
    arm_s     = arm_r;
    to_s      = to_r;
    up_s      = {NUM_FIELDS{1'b0}};
    down_s    = {NUM_FIELDS{1'b0}};
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        hold_s = {HOLD_W{1'b0}};
        arm_s  = 1'b0;
        to_s   = {TO_W{1'b0}};
        if (iSet) begin
          state_s  = ST_EDIT;
          cursor_s = CUR_TOP;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_EDIT: begin
        if (!iSet) begin
          state_s = ST_IDLE;
          hold_s  = {HOLD_W{1'b0}};
          arm_s   = 1'b0;
          to_s    = {TO_W{1'b0}};
        end else if (to_r == TO_MAX) begin
          state_s   = ST_LOCK;
          timeout_s = 1'b1;
          hold_s    = {HOLD_W{1'b0}};
          arm_s     = 1'b0;
          to_s      = {TO_W{1'b0}};
        end else begin
          if (edge_l_s && !edge_r_s) begin
            cursor_s = (cursor_r == CUR_TOP) ? {CUR_W{1'b0}} : cursor_r + CUR_W'(1);
          end else if (edge_r_s && !edge_l_s) begin
            cursor_s = (cursor_r == {CUR_W{1'b0}}) ? CUR_TOP : cursor_r - CUR_W'(1);
          end else begin
            cursor_s = cursor_r;
          end
          // Pulses always target the cursor as it was before any move this cycle
          if (iBtn_U && iBtn_D) begin
            hold_s = {HOLD_W{1'b0}};
            arm_s  = 1'b0;
          end else if (edge_u_s) begin
            up_s   = onehot(cursor_r);
            hold_s = {HOLD_W{1'b0}};
            arm_s  = 1'b1;
          end else if (edge_d_s) begin
            down_s = onehot(cursor_r);
            hold_s = {HOLD_W{1'b0}};
            arm_s  = 1'b1;
          end else if (arm_r && (iBtn_U || iBtn_D)) begin
            if (iTick && (hold_r >= HOLD_LAST)) begin
              up_s   = iBtn_U ? onehot(cursor_r) : {NUM_FIELDS{1'b0}};
              down_s = iBtn_U ? {NUM_FIELDS{1'b0}} : onehot(cursor_r);
              hold_s = HOLD_RELOAD;
            end else if (iTick) begin
              hold_s = hold_r + HOLD_W'(1);
            end else begin
              hold_s = hold_r;
            end
          end else begin
            hold_s = {HOLD_W{1'b0}};
            arm_s  = 1'b0;
          end
          if (edge_u_s || edge_d_s || edge_l_s || edge_r_s || (|(up_s | down_s))) begin
            to_s = {TO_W{1'b0}};
          end else if (iTick && (to_r != TO_MAX)) begin
            to_s = to_r + TO_W'(1);
          end else begin
            to_s = to_r;
          end
        end
      end
      ST_LOCK: begin
        hold_s  = {HOLD_W{1'b0}};
        arm_s   = 1'b0;
        to_s    = {TO_W{1'b0}};
        state_s = iSet ? ST_LOCK : ST_IDLE;
      end
      default: begin
        state_s  = ST_IDLE;
        cursor_s = CUR_TOP;
        hold_s   = {HOLD_W{1'b0}};
        arm_s    = 1'b0;
        to_s     = {TO_W{1'b0}};
      end
    endcase
  end

  // State, counters, button history and registered outputs
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r   <= ST_IDLE;
      cursor_r  <= CUR_TOP;
      hold_r    <= {HOLD_W{1'b0}};
      arm_r     <= 1'b0;
      to_r      <= {TO_W{1'b0}};
      prev_u_r  <= 1'b1;
      prev_d_r  <= 1'b1;
      prev_l_r  <= 1'b1;
      prev_r_r  <= 1'b1;
      up_r      <= {NUM_FIELDS{1'b0}};
      down_r    <= {NUM_FIELDS{1'b0}};
      sel_r     <= {NUM_FIELDS{1'b0}};
      setting_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cursor_r  <= cursor_s;
      hold_r    <= hold_s;
      arm_r     <= arm_s;
      to_r      <= to_s;
      prev_u_r  <= iBtn_U;
      prev_d_r  <= iBtn_D;
      prev_l_r  <= iBtn_L;
      prev_r_r  <= iBtn_R;
      up_r      <= up_s;
      down_r    <= down_s;
      sel_r     <= (state_s == ST_EDIT) ? onehot(cursor_s) : {NUM_FIELDS{1'b0}};
      setting_r <= (state_s == ST_EDIT);
      timeout_r <= timeout_s;
    end
  end

  assign oUp      = up_r;
  assign oDown    = down_r;
  assign oSel     = sel_r;
  assign oSetting = setting_r;
  assign oTimeout = timeout_r;

`ifdef CLOCK_FIELD_SET_BLINK_EN
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  logic [BL_W-1:0] blink_cnt_r, blink_cnt_s;
  logic            blink_r, blink_s;

  // Blink phase: restarts solid on entry, cursor move or any pulse
  always_comb begin
    blink_cnt_s = blink_cnt_r;
    blink_s     = blink_r;
    if (state_s != ST_EDIT) begin
      blink_cnt_s = {BL_W{1'b0}};
      blink_s     = 1'b0;
    end else if ((state_r != ST_EDIT) || (cursor_s != cursor_r) || (|(up_s | down_s))) begin
      blink_cnt_s = {BL_W{1'b0}};
      blink_s     = 1'b1;
    end else if (iTick && (blink_cnt_r == BL_LAST)) begin
      blink_cnt_s = {BL_W{1'b0}};
      blink_s     = ~blink_r;
    end else if (iTick) begin
      blink_cnt_s = blink_cnt_r + BL_W'(1);
      blink_s     = blink_r;
    end else begin
      blink_cnt_s = blink_cnt_r;
      blink_s     = blink_r;
    end
  end

  // Blink counter and gate register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      blink_cnt_r <= {BL_W{1'b0}};
      blink_r     <= 1'b0;
    end else begin
      blink_cnt_r <= blink_cnt_s;
      blink_r     <= blink_s;
    end
  end

  assign oBlink = blink_r;
`else
  assign oBlink = setting_r;
`endif

endmodule

// File: tb/tb_clock_field_set_ctrl.sv
// Self-checking bench for clock_field_set_ctrl: directed scenarios plus random stimulus,
// all compared against an event-level reference model of the set-mode rules.
module tb_clock_field_set_ctrl;

  localparam int NF   = 3;
  localparam int DLY  = 50;
  localparam int RATE = 10;
  localparam int TMO  = 3000;
  localparam int M_IDLE = 0;
  localparam int M_EDIT = 1;
  localparam int M_LOCK = 2;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic iTick = 1'b0, iSet = 1'b0;
  logic iBtn_U = 1'b0, iBtn_D = 1'b0, iBtn_L = 1'b0, iBtn_R = 1'b0;
  logic [NF-1:0] oUp, oDown, oSel;
  logic oSetting, oTimeout, oBlink;

  int checks = 0;
  int failures = 0;

  clock_field_set_ctrl #(
    .NUM_FIELDS(NF), .REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .TIMEOUT(TMO), .BLINK_HALF(250)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iTick(iTick), .iSet(iSet),
    .iBtn_U(iBtn_U), .iBtn_D(iBtn_D), .iBtn_L(iBtn_L), .iBtn_R(iBtn_R),
    .oUp(oUp), .oDown(oDown), .oSel(oSel),
    .oSetting(oSetting), .oTimeout(oTimeout), .oBlink(oBlink)
  );

  always #5 iClk = ~iClk;

  wire [3*NF+2:0] act_all = {oUp, oDown, oSel, oSetting, oTimeout, oBlink};

  // Reference model: mode, cursor position, ticks held since the accepted press
  // (-1 when no repeat is running), ticks since last activity, previous button levels.
  int m_state, m_cur, m_held, m_idle;
  bit m_pu, m_pd, m_pl, m_pr;
  logic [3*NF+2:0] exp_all;

  task automatic model_reset();
    m_state = M_IDLE;
    m_cur   = NF - 1;
    m_held  = -1;
    m_idle  = 0;
    {m_pu, m_pd, m_pl, m_pr} = 4'b1111;
    exp_all = '0;
  endtask

  task automatic model_step(input bit s, u, d, l, r, t);
    bit eu, ed, el, er, to;
    int pre;
    logic [NF-1:0] up, dn, sel;
    eu = u & ~m_pu; ed = d & ~m_pd; el = l & ~m_pl; er = r & ~m_pr;
    up = '0; dn = '0; to = 1'b0;
    if (m_state == M_IDLE) begin
      if (s) begin
        m_state = M_EDIT; m_cur = NF - 1; m_held = -1; m_idle = 0;
      end
    end else if (m_state == M_EDIT) begin
      if (!s) begin
        m_state = M_IDLE; m_held = -1;
      end else if (m_idle >= TMO) begin
        m_state = M_LOCK; to = 1'b1; m_held = -1;
      end else begin
        pre = m_cur;
        if (el && !er) m_cur = (m_cur + 1) % NF;
        else if (er && !el) m_cur = (m_cur + NF - 1) % NF;
        if (u && d) m_held = -1;
        else if (eu) begin up[pre] = 1'b1; m_held = 0; end
        else if (ed) begin dn[pre] = 1'b1; m_held = 0; end
        else if (m_held >= 0 && (u || d)) begin
          if (t) begin
            m_held++;
            if (m_held >= DLY && ((m_held - DLY) % RATE) == 0) begin
              if (u) up[pre] = 1'b1;
              else dn[pre] = 1'b1;
            end
          end
        end else m_held = -1;
        if (eu || ed || el || er || up != '0 || dn != '0) m_idle = 0;
        else if (t && m_idle < TMO) m_idle++;
      end
    end else begin
      if (!s) m_state = M_IDLE;
    end
    {m_pu, m_pd, m_pl, m_pr} = {u, d, l, r};
    sel = '0;
    if (m_state == M_EDIT) sel[m_cur] = 1'b1;
    exp_all = {up, dn, sel, (m_state == M_EDIT), to, (m_state == M_EDIT)};
  endtask

  task automatic step(input bit s, u, d, l, r, t);
    iSet = s; iBtn_U = u; iBtn_D = d; iBtn_L = l; iBtn_R = r; iTick = t;
    @(posedge iClk);
    model_step(s, u, d, l, r, t);
    #1;
  endtask

  task automatic enter_edit();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    iBtn_U = 1'b1;
    #2 iRst = 1'b1;
    #1;
    checks++;
    if (act_all !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h want=%h", act_all, {(3*NF+3){1'b0}});
    end
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    model_reset();
    step(0, 1, 0, 0, 0, 1);
    checks++;
    if (act_all !== exp_all) begin
      failures++; $display("FAIL reset_idle got=%h want=%h", act_all, exp_all);
    end
  endtask

  task automatic test_entry_held();
    int pulses = 0;
    step(1, 1, 0, 0, 0, 0);
    checks++;
    if (oSel !== 3'b100 || oSetting !== 1'b1 || act_all !== exp_all) begin
      failures++; $display("FAIL entry_held sel=%b set=%b want sel=100 set=1", oSel, oSetting);
    end
    for (int i = 0; i < 70; i++) begin
      step(1, 1, 0, 0, 0, 1);
      if (oUp !== 3'b000) pulses++;
      checks++;
      if (act_all !== exp_all) begin
        failures++; $display("FAIL entry_hold i=%0d got=%h want=%h", i, act_all, exp_all);
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL entry_no_pulse got=%0d want=0", pulses);
    end
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    checks++;
    if (oUp !== 3'b100 || act_all !== exp_all) begin
      failures++; $display("FAIL entry_repress oUp=%b want=100", oUp);
    end
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_cursor();
    bit [1:0] lr [10] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
    logic [2:0] want [10] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b100, 3'b100,
                              3'b001, 3'b001, 3'b001, 3'b001};
    enter_edit();
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, lr[i][1], lr[i][0], 0);
      checks++;
      if (oSel !== want[i] || act_all !== exp_all) begin
        failures++; $display("FAIL cursor i=%0d oSel=%b want=%b all=%h model=%h",
                             i, oSel, want[i], act_all, exp_all);
      end
    end
  endtask

  task automatic test_repeat();
    int ups = 0, downs = 0;
    enter_edit();
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    if (oUp[1]) ups++;
    for (int i = 0; i < 81; i++) begin
      if (i < 80) step(1, 1, 0, 0, 0, 1);
      else step(1, 0, 0, 0, 0, 1);
      if (oUp[1]) ups++;
      if (oDown !== 3'b000) downs++;
      checks++;
      if (act_all !== exp_all) begin
        failures++; $display("FAIL repeat i=%0d got=%h want=%h", i, act_all, exp_all);
      end
    end
    checks++;
    if (ups != 5 || downs != 0) begin
      failures++; $display("FAIL repeat_count ups=%0d downs=%0d want 5 and 0", ups, downs);
    end
  endtask

  task automatic test_ud_combo();
    int pulses = 0;
    enter_edit();
    for (int i = 0; i < 61; i++) begin
      step(1, 1, 1, 0, 0, (i > 0));
      if ((oUp | oDown) !== 3'b000) pulses++;
      checks++;
      if (act_all !== exp_all) begin
        failures++; $display("FAIL ud_both i=%0d got=%h want=%h", i, act_all, exp_all);
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL ud_both_pulses got=%0d want=0", pulses);
    end
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    checks++;
    if (oUp !== 3'b100 || oSel !== 3'b010 || act_all !== exp_all) begin
      failures++; $display("FAIL move_and_up oUp=%b oSel=%b want 100 and 010", oUp, oSel);
    end
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    int tos = 0;
    enter_edit();
    for (int i = 0; i < 3100; i++) begin
      step(1, 0, 0, 0, 0, 1);
      if (oTimeout) tos++;
      checks++;
      if (act_all !== exp_all) begin
        failures++; $display("FAIL timeout i=%0d got=%h want=%h", i, act_all, exp_all);
      end
    end
    checks++;
    if (tos != 1 || oSetting !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse count=%0d set=%b want 1 and 0", tos, oSetting);
    end
    for (int i = 0; i < 20; i++) begin
      step(1, i[0], 0, i[1], i[2], 1);
      checks++;
      if (act_all !== exp_all || oSetting !== 1'b0 || oUp !== 3'b000) begin
        failures++; $display("FAIL lock_ignore i=%0d got=%h want=%h", i, act_all, exp_all);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (oSetting !== 1'b1 || oSel !== 3'b100 || act_all !== exp_all) begin
      failures++; $display("FAIL relock_entry set=%b sel=%b want 1 and 100", oSetting, oSel);
    end
  endtask

  task automatic test_exit_edge();
    enter_edit();
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (oUp !== 3'b000 || oSetting !== 1'b0 || act_all !== exp_all) begin
      failures++; $display("FAIL exit_edge oUp=%b set=%b want 000 and 0", oUp, oSetting);
    end
  endtask

  task automatic test_reset_mid_repeat();
    enter_edit();
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 55; i++) step(1, 1, 0, 0, 0, 1);
    iRst = 1'b1;
    #1;
    checks++;
    if (act_all !== '0) begin
      failures++; $display("FAIL reset_mid got=%h want=%h", act_all, {(3*NF+3){1'b0}});
    end
    iBtn_U = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (act_all !== exp_all) begin
      failures++; $display("FAIL reset_mid_after got=%h want=%h", act_all, exp_all);
    end
  endtask

  task automatic test_random();
    bit s = 1'b1, u = 1'b0, d = 1'b0, l = 1'b0, r = 1'b0, t;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) s = ~s;
      if ($urandom_range(0, 9) == 0) u = ~u;
      if ($urandom_range(0, 11) == 0) d = ~d;
      if ($urandom_range(0, 14) == 0) l = ~l;
      if ($urandom_range(0, 14) == 0) r = ~r;
      t = 1'($urandom_range(0, 1));
      step(s, u, d, l, r, t);
      checks++;
      if (act_all !== exp_all) begin
        failures++; $display("FAIL random i=%0d got=%h want=%h", i, act_all, exp_all);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_entry_held();
    test_cursor();
    test_repeat();
    test_ud_combo();
    test_exit_edge();
    test_timeout();
    test_reset_mid_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
